fifo_burst_reader: RTL

- Read-side controller for the team's FIFO block, which has 1-cycle read latency: q is valid the cycle after rden.
- On a start pulse, pops exactly len words from the FIFO and presents them downstream as an in-order valid/ready stream, then pulses done.
- Sits between a FIFO and its consumer, for example a MAC array.
- Hides the FIFO read latency behind a 2-entry skid buffer, so sustained throughput is 1 word per cycle.

---
 rtl/fifo_burst_reader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops len words from a 1-cycle-latency FIFO into a valid/ready stream.
// Optional out_last output is enabled by defining FIFO_BURST_LAST_EN.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rden,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LEN_WIDTH-1:0]  rd_count,
`ifdef FIFO_BURST_LAST_EN
    output logic                  out_last,
`endif
    output logic [1:0]            fsm_state
);

    // Handshake: a word moves downstream on any rising edge where out_valid && out_ready;
    // out_valid never drops and out_data never changes while waiting for out_ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  issued;
    logic [DATA_WIDTH-1:0] buf0, buf1;
    logic [1:0]            buf_count;
    logic                  inflight;
    logic                  pop;
    logic                  rden;
    logic [2:0]            occupancy;

    assign out_valid = (buf_count != 2'd0);
    assign out_data  = buf0;
    assign pop       = out_valid & out_ready;
    // Words held after this edge if no new read were issued; a read is allowed only below 2.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};

    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign fifo_rden = rden;
    assign fsm_state = state;
`ifdef FIFO_BURST_LAST_EN
    assign out_last  = out_valid && (rd_count == len_r - ONE);
`endif

    always_comb begin
        state_nxt = state;
        rden      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                rden = !fifo_empty && (issued < len_r) && (occupancy < 3'd2);
                if (pop && (rd_count + ONE == len_r)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len_r    <= '0;
            issued   <= '0;
            rd_count <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rden;
            if (state == S_IDLE && start) begin
                len_r    <= len;
                issued   <= '0;
                rd_count <= '0;
            end else begin
                if (rden) issued <= issued + ONE;
                if (pop && rd_count != len_r) rd_count <= rd_count + ONE;
            end
        end
    end

    // Two-entry skid buffer with buf0 as head; captures come from the read issued last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0      <= '0;
            buf1      <= '0;
            buf_count <= 2'd0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (buf_count == 2'd0) buf0 <= fifo_q;
                    else                   buf1 <= fifo_q;
                    buf_count <= buf_count + 2'd1;
                end
                2'b01: begin
                    buf0      <= buf1;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        buf0 <= fifo_q;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
